// File: rtl/dpc_cio_pkg.sv
// Shared definitions for the console I/O responder: state encoding, default symbol
// width and status-panel bit positions.
package dpc_cio_pkg;

  localparam int unsigned CioDataWidth = 8;

  typedef logic [2:0] cio_state_t;

  localparam cio_state_t StIdle    = 3'd0;
  localparam cio_state_t StOutSend = 3'd1;
  localparam cio_state_t StOutAck  = 3'd2;
  localparam cio_state_t StInWait  = 3'd3;
  localparam cio_state_t StInAck   = 3'd4;
  localparam cio_state_t StInHold  = 3'd5;

  // Bit positions of the sticky flags on the status panel.
  localparam int unsigned StatProtoErrBit   = 0;
  localparam int unsigned StatRxOverflowBit = 1;

endpackage

// File: rtl/cio_rx_fifo.sv
// Receive FIFO for console input: registered occupancy, and a one-cycle overflow
// strobe when a byte arrives while full and nothing is leaving.
module cio_rx_fifo
  import dpc_cio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CioDataWidth,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      head,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCount);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_push = push && (!full || do_pop);

  assign overflow = push && full && !do_pop;
  assign head     = mem[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cio_responder.sv
// Peripheral end of the Cout/CinReq/CioAcq console handshake: forwards output symbols
// to a valid/ready transmitter and serves input symbols from the RX FIFO.
module cio_responder
  import dpc_cio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CioDataWidth,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ACQ_HOLD   = 2
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic                        Cout,
  input  logic                        CinReq,
  input  logic [DATA_WIDTH-1:0]       CoutData,
  output logic                        CioAcq,
  output logic [DATA_WIDTH-1:0]       CinData,
  input  logic                        RxValid,
  input  logic [DATA_WIDTH-1:0]       RxData,
  output logic                        TxValid,
  output logic [DATA_WIDTH-1:0]       TxData,
  input  logic                        TxReady,
  output logic [$clog2(FIFO_DEPTH):0] RxCount,
  output logic                        RxOverflow,
  output logic                        ProtoErr
);

  localparam int unsigned HoldW = (ACQ_HOLD > 1) ? $clog2(ACQ_HOLD + 1) : 1;

  cio_state_t            state_q, state_d;
  logic                  acq_q, acq_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0] cin_data_q, cin_data_d;
  logic [HoldW-1:0]      hold_q, hold_d;
  logic                  proto_err_q, proto_err_d;
  logic                  rx_overflow_q;

  logic                  rx_pop, rx_empty, rx_drop;
  logic [DATA_WIDTH-1:0] rx_head;

  cio_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .push      (RxValid),
    .push_data (RxData),
    .pop       (rx_pop),
    .head      (rx_head),
    .empty     (rx_empty),
    .count     (RxCount),
    .overflow  (rx_drop)
  );

  always_comb begin
    state_d     = state_q;
    acq_d       = acq_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    cin_data_d  = cin_data_q;
    hold_d      = hold_q;
    proto_err_d = proto_err_q;
    rx_pop      = 1'b0;

    case (state_q)
      StIdle: begin
        if (Cout) begin
          tx_data_d  = CoutData;
          tx_valid_d = 1'b1;
          state_d    = StOutSend;
          if (CinReq) proto_err_d = 1'b1;
        end else if (CinReq) begin
          state_d = StInWait;
        end
      end
      StOutSend: begin
        if (TxReady) begin
          tx_valid_d = 1'b0;
          // A decoder that already dropped Cout gets no acknowledge.
          if (Cout) begin
            acq_d   = 1'b1;
            state_d = StOutAck;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StOutAck: begin
        if (!Cout) begin
          acq_d   = 1'b0;
          state_d = StIdle;
        end
      end
      StInWait: begin
        if (!CinReq) begin
          state_d = StIdle;
        end else if (!rx_empty) begin
          cin_data_d = rx_head;
          acq_d      = 1'b1;
          state_d    = StInAck;
        end
      end
      StInAck: begin
        if (!CinReq) begin
          if (ACQ_HOLD == 0) begin
            acq_d   = 1'b0;
            rx_pop  = 1'b1;
            state_d = StIdle;
          end else begin
            hold_d  = HoldW'(ACQ_HOLD);
            state_d = StInHold;
          end
        end
      end
      StInHold: begin
        // Release on the cycle the count would reach zero.
        if (hold_q <= HoldW'(1)) begin
          acq_d   = 1'b0;
          rx_pop  = 1'b1;
          hold_d  = '0;
          state_d = StIdle;
        end else begin
          hold_d = hold_q - HoldW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= StIdle;
      acq_q         <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      cin_data_q    <= '0;
      hold_q        <= '0;
      proto_err_q   <= 1'b0;
      rx_overflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acq_q         <= acq_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      cin_data_q    <= cin_data_d;
      hold_q        <= hold_d;
      proto_err_q   <= proto_err_d;
      rx_overflow_q <= rx_overflow_q | rx_drop;
    end
  end

  assign CioAcq     = acq_q;
  assign CinData    = cin_data_q;
  assign TxValid    = tx_valid_q;
  assign TxData     = tx_data_q;
  assign RxOverflow = rx_overflow_q;
  assign ProtoErr   = proto_err_q;

endmodule

// File: tb/tb_cio_responder.sv
// Randomised scoreboard bench for cio_responder: a queue-based FIFO model predicts
// every transmitted and received symbol, monitors compare as the DUT presents them.
module tb_cio_responder;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 2;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Cout = 1'b0, CinReq = 1'b0, RxValid = 1'b0, TxReady = 1'b0;
  logic [DW-1:0] CoutData = '0, RxData = '0;
  logic          CioAcq, TxValid, RxOverflow, ProtoErr;
  logic [DW-1:0] CinData, TxData;
  logic [2:0]    RxCount;

  cio_responder #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .ACQ_HOLD   (HOLD)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Cout       (Cout),
    .CinReq     (CinReq),
    .CoutData   (CoutData),
    .CioAcq     (CioAcq),
    .CinData    (CinData),
    .RxValid    (RxValid),
    .RxData     (RxData),
    .TxValid    (TxValid),
    .TxData     (TxData),
    .TxReady    (TxReady),
    .RxCount    (RxCount),
    .RxOverflow (RxOverflow),
    .ProtoErr   (ProtoErr)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_tx[$];
  logic [DW-1:0] exp_cin[$];
  bit            ovf_exp = 1'b0;
  bit            pe_exp  = 1'b0;
  bit            in_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard monitors: transmitter handshakes and input acknowledges.
  initial begin
    logic prev_acq;
    prev_acq = 1'b0;
    forever begin
      @(negedge Clk);
      if (Rst_n) begin
        if (TxValid && TxReady) begin
          if (exp_tx.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected: got %0h expected none", TxData);
          end else begin
            check("tx_data", TxData, exp_tx.pop_front());
          end
        end
        if (CioAcq && !prev_acq && in_mode) begin
          if (exp_cin.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL cin_unexpected: got %0h expected none", CinData);
          end else begin
            check("cin_data", CinData, exp_cin.pop_front());
          end
        end
        prev_acq = CioAcq;
      end else begin
        prev_acq = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_model();
    model_q.delete();
    exp_tx.delete();
    exp_cin.delete();
    ovf_exp = 1'b0;
    pe_exp  = 1'b0;
  endtask

  task automatic rx_push(input logic [DW-1:0] b);
    RxValid = 1'b1;
    RxData  = b;
    step();
    RxValid = 1'b0;
    RxData  = DW'($urandom);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else ovf_exp = 1'b1;
    check("rx_count", RxCount, model_q.size());
    check("rx_overflow", RxOverflow, ovf_exp);
  endtask

  task automatic do_out(input logic [DW-1:0] b, input int delay, input bit rnd,
                        input bit with_cin);
    bit got;
    in_mode  = 1'b0;
    Cout     = 1'b1;
    CinReq   = with_cin;
    CoutData = b;
    TxReady  = 1'b0;
    exp_tx.push_back(b);
    if (with_cin) pe_exp = 1'b1;
    step();
    check("tx_valid_rise", TxValid, 1);
    for (int i = 0; i < delay; i++) begin
      if (rnd) CoutData = DW'($urandom);
      check("tx_hold", {TxValid, TxData}, {1'b1, b});
      step();
    end
    got = 1'b0;
    for (int n = 0; n < 64 && !got; n++) begin
      TxReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      got = CioAcq;
    end
    TxReady = 1'b0;
    check("out_ack", CioAcq, 1);
    check("tx_valid_drop", TxValid, 0);
    Cout   = 1'b0;
    CinReq = 1'b0;
    step();
    check("out_release", CioAcq, 0);
    check("proto_err", ProtoErr, pe_exp);
  endtask

  task automatic do_out_abort(input logic [DW-1:0] b);
    in_mode  = 1'b0;
    Cout     = 1'b1;
    CoutData = b;
    TxReady  = 1'b0;
    exp_tx.push_back(b);
    step();
    Cout = 1'b0;
    step();
    step();
    check("abort_tx_held", {TxValid, TxData}, {1'b1, b});
    TxReady = 1'b1;
    step();
    TxReady = 1'b0;
    check("abort_no_ack", {CioAcq, TxValid}, 0);
    step();
    check("abort_idle", CioAcq, 0);
  endtask

  // Input read. With an empty FIFO the request waits pre_wait cycles, then byte eb arrives.
  task automatic do_in(input int pre_wait, input logic [DW-1:0] eb, input bit push_on_pop,
                       input logic [DW-1:0] pb);
    int            n, acks;
    bit            got, was_empty;
    logic [DW-1:0] want;
    in_mode   = 1'b1;
    CinReq    = 1'b1;
    was_empty = (model_q.size() == 0);
    if (was_empty) begin
      acks = 0;
      for (int i = 0; i < pre_wait; i++) begin
        step();
        acks += int'(CioAcq);
      end
      check("in_wait_empty", acks, 0);
      rx_push(eb);
    end
    want = model_q[0];
    exp_cin.push_back(want);
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      step();
      n++;
      got = CioAcq;
    end
    check("in_latency", n, was_empty ? 1 : 2);
    CinReq = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      step();
      check("in_hold_acq", CioAcq, 1);
      check("in_hold_count", RxCount, model_q.size());
    end
    if (push_on_pop) begin
      RxValid = 1'b1;
      RxData  = pb;
    end
    step();
    RxValid = 1'b0;
    void'(model_q.pop_front());
    if (push_on_pop) model_q.push_back(pb);
    check("in_release", CioAcq, 0);
    check("in_pop_count", RxCount, model_q.size());
    check("cin_stable", CinData, want);
    check("in_overflow", RxOverflow, ovf_exp);
    in_mode = 1'b0;
  endtask

  task automatic do_in_abort();
    in_mode = 1'b1;
    CinReq  = 1'b1;
    repeat (3) step();
    CinReq = 1'b0;
    step();
    check("in_abort_acq", CioAcq, 0);
    step();
    check("in_abort_count", RxCount, model_q.size());
    in_mode = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] b;
    int            op;

    // Reset state.
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_acq", CioAcq, 0);
    check("rst_txv", TxValid, 0);
    check("rst_txd", TxData, 0);
    check("rst_cin", CinData, 0);
    check("rst_cnt", RxCount, 0);
    check("rst_ovf", RxOverflow, 0);
    check("rst_pe", ProtoErr, 0);
    Rst_n = 1'b1;
    step();

    // Output with back-pressure.
    do_out(8'h41, 3, 1'b0, 1'b0);

    // Input from a pre-filled FIFO.
    rx_push(8'h35);
    do_in(0, 8'h00, 1'b0, 8'h00);

    // Input that waits on an empty FIFO.
    do_in(10, 8'h0A, 1'b0, 8'h00);

    // Overflow, then read back the oldest three.
    for (int i = 1; i <= 5; i++) rx_push(DW'(i));
    check("ovf_full_count", RxCount, 4);
    check("ovf_sticky", RxOverflow, 1);
    repeat (3) do_in(0, 8'h00, 1'b0, 8'h00);

    // Push on the pop cycle of a full FIFO.
    Rst_n = 1'b0;
    #1;
    clear_model();
    step();
    Rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) rx_push(8'h60 + DW'(i));
    do_in(0, 8'h00, 1'b1, 8'hC3);
    check("pop_push_count", RxCount, 4);
    check("pop_push_ovf", RxOverflow, 0);
    repeat (4) do_in(0, 8'h00, 1'b0, 8'h00);

    do_out_abort(8'h7E);

    // Simultaneous requests: output serviced, ProtoErr sticks.
    do_out(8'h5A, 1, 1'b0, 1'b1);
    do_out(8'h11, 0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an output transfer.
    rx_push(8'h21);
    rx_push(8'h22);
    Cout     = 1'b1;
    CoutData = 8'h99;
    TxReady  = 1'b0;
    step();
    step();
    check("pre_rst_txv", TxValid, 1);
    #2;
    Rst_n = 1'b0;
    #1;
    clear_model();
    check("arst_txv", TxValid, 0);
    check("arst_acq", CioAcq, 0);
    check("arst_cnt", RxCount, 0);
    check("arst_pe", ProtoErr, 0);
    Cout = 1'b0;
    step();
    Rst_n   = 1'b1;
    TxReady = 1'b1;
    step();
    step();
    check("post_rst_txv", TxValid, 0);
    TxReady = 1'b0;

    // Randomised traffic.
    for (int it = 0; it < 200; it++) begin
      op = int'($urandom_range(0, 9));
      b  = DW'($urandom);
      if (op <= 3) begin
        rx_push(b);
      end else if (op <= 5) begin
        do_out(b, int'($urandom_range(0, 3)), 1'b1, 1'b0);
      end else if (op <= 8) begin
        if (model_q.size() > 0) do_in(0, 8'h00, 1'($urandom_range(0, 1)), b);
        else do_in_abort();
      end else begin
        step();
      end
    end

    step();
    check("tx_queue_drained", exp_tx.size(), 0);
    check("cin_queue_drained", exp_cin.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
